// File: rtl/rm_ecc_scrub_ctrl.sv
// Background scrubber for the Reed-Muller ECC core: walks memory, decodes each
// codeword, and writes back re-encoded data whenever the core corrected an error.
module rm_ecc_scrub_ctrl #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CW_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [CW_WIDTH-1:0]    mem_wdata,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [CW_WIDTH-1:0]    mem_rdata,
   output logic                   ecc_encode_en,
   output logic                   ecc_decode_en,
   output logic [DATA_WIDTH-1:0]  ecc_data_in,
   output logic [63:0]            ecc_codeword_in,
   input  logic [63:0]            ecc_codeword_out,
   input  logic [DATA_WIDTH-1:0]  ecc_data_out,
   input  logic                   ecc_error_detected,
   input  logic                   ecc_error_corrected,
   input  logic                   ecc_valid_out,
   output logic [COUNT_WIDTH-1:0] corr_count,
   output logic [COUNT_WIDTH-1:0] uncorr_count,
   output logic [ADDR_WIDTH-1:0]  last_err_addr,
   output logic                   last_err_valid
);

   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, DEC, DEC_WAIT, ENC, ENC_WAIT, WR_REQ, NEXT
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;

   // Only the low CW_WIDTH bits of the encoded codeword are stored.
   logic unused_cw_bits;
   assign unused_cw_bits = ^(ecc_codeword_out >> CW_WIDTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         addr            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         ecc_encode_en   <= 1'b0;
         ecc_decode_en   <= 1'b0;
         ecc_data_in     <= '0;
         ecc_codeword_in <= '0;
         corr_count      <= '0;
         uncorr_count    <= '0;
         last_err_addr   <= '0;
         last_err_valid  <= 1'b0;
      end else begin
         done          <= 1'b0;
         ecc_encode_en <= 1'b0;
         ecc_decode_en <= 1'b0;
         if (abort && state != IDLE) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state          <= RD_REQ;
                  addr           <= '0;
                  busy           <= 1'b1;
                  mem_req        <= 1'b1;
                  mem_we         <= 1'b0;
                  mem_addr       <= '0;
                  corr_count     <= '0;
                  uncorr_count   <= '0;
                  last_err_valid <= 1'b0;
               end
               RD_REQ: if (mem_gnt) begin
                  state   <= RD_WAIT;
                  mem_req <= 1'b0;
               end
               // The read word is captured straight into the decode-input register.
               RD_WAIT: if (mem_rvalid) begin
                  state           <= DEC;
                  ecc_codeword_in <= 64'(mem_rdata);
                  ecc_decode_en   <= 1'b1;
               end
               DEC: state <= DEC_WAIT;
               DEC_WAIT: begin
                  if (ecc_error_corrected) begin
                     state         <= ENC;
                     ecc_data_in   <= ecc_data_out;
                     ecc_encode_en <= 1'b1;
                     if (corr_count != '1) corr_count <= corr_count + 1'b1;
                  end else if (ecc_error_detected) begin
                     state          <= NEXT;
                     last_err_addr  <= addr;
                     last_err_valid <= 1'b1;
                     if (uncorr_count != '1) uncorr_count <= uncorr_count + 1'b1;
                  end else begin
                     state <= NEXT;
                  end
               end
               ENC: state <= ENC_WAIT;
               ENC_WAIT: if (ecc_valid_out) begin
                  state     <= WR_REQ;
                  mem_wdata <= ecc_codeword_out[CW_WIDTH-1:0];
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
               end
               WR_REQ: if (mem_gnt) begin
                  state   <= NEXT;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
               NEXT: begin
                  if (addr == LAST_ADDR) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= RD_REQ;
                     addr     <= addr + 1'b1;
                     mem_addr <= addr + 1'b1;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
